// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_modport UART.
//   Register addresses, IIR interrupt codes, LSR bit positions and the
//   transmit/receive state encodings.
package uart_pkg;

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_IIR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_MSR = 3'd6;
  localparam logic [2:0] ADDR_SCR = 3'd7;

  localparam logic [3:0] IIR_RLS  = 4'h6;
  localparam logic [3:0] IIR_RDA  = 4'h4;
  localparam logic [3:0] IIR_THRE = 4'h2;
  localparam logic [3:0] IIR_NONE = 4'h1;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x baud tick generator.
//   wb_clk_i  - clock
//   wb_rst_i  - asynchronous active-high reset
//   divisor   - current {DLM,DLL}; 0 stops ticking
//   load      - divisor register is being written this clock
//   load_val  - divisor value taking effect with load
//   tick      - one-clock pulse every divisor clocks
module uart_baud_gen #(
  parameter logic [15:0] DIV_RST = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] divisor,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        tick
);

  localparam logic [15:0] CNT_RST = (DIV_RST == 16'h0000) ? 16'h0000 : DIV_RST - 16'd1;

  logic [15:0] cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt  <= CNT_RST;
      tick <= 1'b0;
    end else if (load) begin
      // restart from the new divisor so the first period is full length
      cnt  <= load_val - 16'd1;
      tick <= 1'b0;
    end else if (divisor == 16'h0000) begin
      tick <= 1'b0;
    end else if (cnt == 16'h0000) begin
      cnt  <= divisor - 16'd1;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - 16'd1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_modport.sv
// uart_modport: Wishbone-slave UART, 16550-style map with single-byte
// holding registers, 8N1 framing, 16x baud generator, level interrupt.
//   wb_clk_i/wb_rst_i          - clock, async active-high reset
//   wb_adr_i/dat_i/we/stb/cyc  - Wishbone request (wb_sel_i ignored)
//   wb_dat_o/wb_ack_o          - registered read data and one-clock ack
//   int_o                      - level interrupt, active high
//   baud_o                     - 16x baud tick
//   stx_pad_o/srx_pad_i        - serial pads
// Optional macro UART_LOOPBACK_EN: MCR[4] loops the transmit stream into
// the receiver and holds stx_pad_o high.
//
// tx state | meaning
// TX_IDLE  | line high, waiting for THR to be full
// TX_START | start bit (0), 16 ticks
// TX_DATA  | 8 data bits LSB first, 16 ticks each
// TX_STOP  | stop bit (1), 16 ticks
//
// rx state | meaning
// RX_IDLE  | waiting for falling edge on synchronised rx
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | sampling 8 data bits then stop bit every 16 ticks
module uart_modport
  import uart_pkg::*;
#(
  parameter logic [15:0] DIV_RST     = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [3:0] wb_sel_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       int_o,
  output logic       baud_o,
  output logic       stx_pad_o,
  input  logic       srx_pad_i
);

  logic       unused_sel;
  logic [2:0] ier;
  logic [7:0] lcr, mcr, scr, dll, dlm, thr, rbr, lsr, rd_mux;
  logic       thre, thre_pend, dr, oe, fe, dlab, tick, loop_en;
  logic       req, wr, rd, thr_wr, dll_wr, dlm_wr, ier_wr, rbr_rd, lsr_rd, iir_rd;
  logic [3:0] iir;

  assign unused_sel = ^wb_sel_i;

  assign dlab   = lcr[7];
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = req & wb_we_i;
  assign rd     = req & ~wb_we_i;
  assign thr_wr = wr & (wb_adr_i == ADDR_RBR) & ~dlab;
  assign dll_wr = wr & (wb_adr_i == ADDR_RBR) & dlab;
  assign dlm_wr = wr & (wb_adr_i == ADDR_IER) & dlab;
  assign ier_wr = wr & (wb_adr_i == ADDR_IER) & ~dlab;
  assign rbr_rd = rd & (wb_adr_i == ADDR_RBR) & ~dlab;
  assign lsr_rd = rd & (wb_adr_i == ADDR_LSR);
  assign iir_rd = rd & (wb_adr_i == ADDR_IIR);

`ifdef UART_LOOPBACK_EN
  assign loop_en = mcr[4];
`else
  assign loop_en = 1'b0;
`endif

  uart_baud_gen #(.DIV_RST(DIV_RST)) u_baud (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .divisor  ({dlm, dll}),
    .load     (dll_wr | dlm_wr),
    .load_val (dll_wr ? {dlm, wb_dat_i} : {wb_dat_i, dll}),
    .tick     (tick)
  );
  assign baud_o = tick;

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_state_n;
  logic [3:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       tx_load, tx_line;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_load    = 1'b0;
    unique case (tx_state)
      TX_IDLE: if (!thre) begin
        tx_load    = 1'b1;
        tx_shift_n = thr;
        tx_cnt_n   = '0;
        tx_state_n = TX_START;
      end
      TX_START: if (tick) begin
        tx_cnt_n = tx_cnt + 4'd1;
        if (tx_cnt == 4'd15) begin
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: if (tick) begin
        tx_cnt_n = tx_cnt + 4'd1;
        if (tx_cnt == 4'd15) begin
          tx_shift_n = {1'b1, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: if (tick) begin
        tx_cnt_n = tx_cnt + 4'd1;
        if (tx_cnt == 4'd15) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign tx_line   = (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
  assign stx_pad_o = loop_en ? 1'b1 : tx_line;

  // ---------------- receiver ----------------
  rx_state_t             rx_state, rx_state_n;
  logic [3:0]            rx_cnt, rx_cnt_n, rx_bit, rx_bit_n;
  logic [7:0]            rx_shift, rx_shift_n;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                  rx_s, rx_prev, rx_done;

  assign rx_s = rx_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[SYNC_STAGES-2:0], loop_en ? tx_line : srx_pad_i};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_START;
      end
      RX_START: if (tick) begin
        rx_cnt_n = rx_cnt + 4'd1;
        if (rx_cnt == 4'd7) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        rx_cnt_n = rx_cnt + 4'd1;
        if (rx_cnt == 4'd15) begin
          if (rx_bit == 4'd8) begin
            rx_done    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_shift_n = {rx_s, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 4'd1;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- status, interrupts, bus ----------------
  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = dr;
    lsr[LSR_OE]   = oe;
    lsr[LSR_FE]   = fe;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = thre & (tx_state == TX_IDLE);
  end

  always_comb begin
    if (ier[2] && (oe || fe))               iir = IIR_RLS;
    else if (ier[0] && dr)                  iir = IIR_RDA;
    else if (ier[1] && thre && thre_pend)   iir = IIR_THRE;
    else                                    iir = IIR_NONE;
  end

  always_comb begin
    rd_mux = '0;
    unique case (wb_adr_i)
      ADDR_RBR: rd_mux = dlab ? dll : rbr;
      ADDR_IER: rd_mux = dlab ? dlm : {5'b0, ier};
      ADDR_IIR: rd_mux = {4'b0, iir};
      ADDR_LCR: rd_mux = lcr;
      ADDR_MCR: rd_mux = mcr;
      ADDR_LSR: rd_mux = lsr;
      ADDR_MSR: rd_mux = '0;
      ADDR_SCR: rd_mux = scr;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      int_o     <= 1'b0;
      ier       <= '0;
      lcr       <= 8'h03;
      mcr       <= '0;
      scr       <= '0;
      dll       <= DIV_RST[7:0];
      dlm       <= DIV_RST[15:8];
      thr       <= '0;
      thre      <= 1'b1;
      thre_pend <= 1'b0;
      rbr       <= '0;
      dr        <= 1'b0;
      oe        <= 1'b0;
      fe        <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rd_mux : 8'h00;
      int_o    <= ~iir[0];

      if (dll_wr) dll <= wb_dat_i;
      if (dlm_wr) dlm <= wb_dat_i;
      if (ier_wr) ier <= wb_dat_i[2:0];
      if (wr && wb_adr_i == ADDR_LCR) lcr <= wb_dat_i;
      if (wr && wb_adr_i == ADDR_MCR) mcr <= wb_dat_i;
      if (wr && wb_adr_i == ADDR_SCR) scr <= wb_dat_i;

      // a THR write while full is dropped
      if (thr_wr && thre) begin
        thr  <= wb_dat_i;
        thre <= 1'b0;
      end else if (tx_load) begin
        thre <= 1'b1;
      end

      if (tx_load || (ier_wr && wb_dat_i[1] && !ier[1]))
        thre_pend <= 1'b1;
      else if (thr_wr || (iir_rd && iir == IIR_THRE))
        thre_pend <= 1'b0;

      // a completing byte wins over a same-clock RBR read or LSR read
      if (rx_done) begin
        rbr <= rx_shift;
        dr  <= 1'b1;
        if (dr && !rbr_rd) oe <= 1'b1;
        else if (lsr_rd)   oe <= 1'b0;
        if (!rx_s)         fe <= 1'b1;
        else if (lsr_rd)   fe <= 1'b0;
      end else begin
        if (rbr_rd) dr <= 1'b0;
        if (lsr_rd) begin
          oe <= 1'b0;
          fe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_modport.sv
module tb_uart_modport;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] wb_adr = '0;
  logic [3:0] wb_sel = 4'hF;
  logic [7:0] wb_dat_i = '0;
  logic [7:0] wb_dat_o;
  logic       wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic       wb_ack, int_o, baud_o, stx, srx = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  uart_modport dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (wb_adr),
    .wb_sel_i  (wb_sel),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_we_i   (wb_we),
    .wb_stb_i  (wb_stb),
    .wb_cyc_i  (wb_cyc),
    .wb_ack_o  (wb_ack),
    .int_o     (int_o),
    .baud_o    (baud_o),
    .stx_pad_o (stx),
    .srx_pad_i (srx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // called 1ns after a rising edge; returns 1ns after the edge following the ack
  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [7:0] din,
                         output logic [7:0] dout);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = din;
    @(posedge clk); #1;
    check("ack_high", {15'b0, wb_ack}, 16'd1);
    dout = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check("ack_single", {15'b0, wb_ack}, 16'd0);
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [7:0] din);
    logic [7:0] d;
    wb_xfer(1'b1, adr, din, d);
  endtask

  task automatic read_check(input string tag, input logic [2:0] adr, input logic [7:0] exp);
    logic [7:0] d;
    wb_xfer(1'b0, adr, 8'h00, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      srx = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    srx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] tx_exp;
    int ticks;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stx",  {15'b0, stx},    16'd1);
    check("rst_int",  {15'b0, int_o},  16'd0);
    check("rst_ack",  {15'b0, wb_ack}, 16'd0);
    check("rst_dato", {8'h00, wb_dat_o}, 16'h0000);
    rst = 1'b0;

    // divisor resets to 0: no ticks at all
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (baud_o) ticks++;
    end
    check("div0_no_tick", 16'(ticks), 16'd0);

    read_check("rst_lsr", 3'd5, 8'h60);
    read_check("rst_iir", 3'd2, 8'h01);
    read_check("rst_lcr", 3'd3, 8'h03);
    read_check("rst_ier", 3'd1, 8'h00);

    wb_write(3'd7, 8'hA5);
    read_check("scr", 3'd7, 8'hA5);
    read_check("msr", 3'd6, 8'h00);

    wb_write(3'd3, 8'h80);
    wb_write(3'd0, 8'h01);
    wb_write(3'd1, 8'h00);
    read_check("dll", 3'd0, 8'h01);
    wb_write(3'd3, 8'h03);
    check("baud_div1", {15'b0, baud_o}, 16'd1);

    // transmit 0x55: THR loads on the write clock, shifter takes it next clock
    wb_write(3'd0, 8'h55);
    read_check("lsr_tx_busy", 3'd5, 8'h20);
    repeat (5) @(posedge clk);
    #1;
    tx_exp = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), {15'b0, stx}, {15'b0, tx_exp[i]});
      repeat (16) @(posedge clk);
      #1;
    end
    check("tx_idle_line", {15'b0, stx}, 16'd1);
    read_check("lsr_temt", 3'd5, 8'h60);

    // start glitch shorter than half a bit must be ignored
    srx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    read_check("lsr_glitch", 3'd5, 8'h60);

    send_frame(8'hC3, 1'b1);
    read_check("lsr_dr", 3'd5, 8'h61);
    read_check("rbr_c3", 3'd0, 8'hC3);
    read_check("lsr_dr_clr", 3'd5, 8'h60);

    wb_write(3'd1, 8'h01);
    send_frame(8'h3C, 1'b1);
    check("int_rda", {15'b0, int_o}, 16'd1);
    read_check("iir_rda", 3'd2, 8'h04);
    read_check("rbr_3c", 3'd0, 8'h3C);
    check("int_rda_clr", {15'b0, int_o}, 16'd0);

    send_frame(8'hA1, 1'b1);
    send_frame(8'h5A, 1'b1);
    read_check("lsr_oe", 3'd5, 8'h63);
    read_check("rbr_overwrite", 3'd0, 8'h5A);
    read_check("lsr_oe_clr", 3'd5, 8'h60);

    wb_write(3'd1, 8'h04);
    send_frame(8'h81, 1'b0);
    check("int_rls", {15'b0, int_o}, 16'd1);
    read_check("iir_rls", 3'd2, 8'h06);
    read_check("lsr_fe", 3'd5, 8'h69);
    check("int_rls_clr", {15'b0, int_o}, 16'd0);
    read_check("rbr_81", 3'd0, 8'h81);
    read_check("lsr_fe_clr", 3'd5, 8'h60);

    // enabling the THRE interrupt with THR already empty raises it once
    wb_write(3'd1, 8'h02);
    check("int_thre", {15'b0, int_o}, 16'd1);
    read_check("iir_thre", 3'd2, 8'h02);
    read_check("iir_thre_clr", 3'd2, 8'h01);
    check("int_thre_clr", {15'b0, int_o}, 16'd0);
    read_check("ier_rd", 3'd1, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
